// File: rtl/imm12_encoder_if.sv
// Handshake and result bundle for the imm12 encoder.
// The master side presents a 32-bit constant and takes the result.
// The slave side is the encoder itself.
interface imm12_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] value;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] imm12;
  logic        encodable;
  logic        inverted;
  logic        busy;

  modport master (
    output in_valid, value, out_ready,
    input  in_ready, out_valid, imm12, encodable, inverted, busy
  );

  modport slave (
    input  in_valid, value, out_ready,
    output in_ready, out_valid, imm12, encodable, inverted, busy
  );
endinterface

// File: rtl/imm12_encoder.sv
// Iterative encoder for data-processing immediates.
// Searches for {rotate_imm, imm8} such that ROR(imm8, 2*rotate_imm) == value,
// testing one rotation per clock and always reporting the smallest rotation.
// Optional feature macro: IMM_INV_EN -- when defined, a failed first pass
// retries with ~value and flags a hit there as inverted (MVN form).
module imm12_encoder (
  input logic            clk,
  input logic            rst,
  imm12_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_val;
  logic [3:0]  r_rotCnt;
  logic        r_outValid;
  logic [11:0] r_imm12;
  logic        r_encodable;
`ifdef IMM_INV_EN
  logic        r_pass;
  logic        r_inverted;
`endif

  // ROL(r_val, 2*rot) is taken as a 32-bit window of the value concatenated
  // with itself; the low two bits of the second copy are never reachable
  // (max rotation is 30), so they are left out of the concatenation.
  logic [61:0] w_dbl;
  logic [5:0]  w_top;
  logic [31:0] w_rol;
  logic        w_hit;

  assign w_dbl = {r_val, r_val[31:2]};
  assign w_top = 6'd61 - {1'b0, r_rotCnt, 1'b0};
  assign w_rol = w_dbl[w_top -: 32];
  assign w_hit = (w_rol[31:8] == 24'd0);

  // Main search FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rotCnt    <= 4'd0;
      r_outValid  <= 1'b0;
      r_imm12     <= 12'h000;
      r_encodable <= 1'b0;
`ifdef IMM_INV_EN
      r_pass      <= 1'b0;
      r_inverted  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_val    <= bus.value;
            r_rotCnt <= 4'd0;
`ifdef IMM_INV_EN
            r_pass   <= 1'b0;
`endif
            r_state  <= SEARCH;
          end
        end

        SEARCH: begin
          if (w_hit) begin
            r_imm12     <= {r_rotCnt, w_rol[7:0]};
            r_encodable <= 1'b1;
`ifdef IMM_INV_EN
            r_inverted  <= r_pass;
`endif
            r_outValid  <= 1'b1;
            r_state     <= DONE;
          end else if (r_rotCnt != 4'd15) begin
            r_rotCnt <= r_rotCnt + 4'd1;
`ifdef IMM_INV_EN
          end else if (!r_pass) begin
            r_val    <= ~r_val;
            r_pass   <= 1'b1;
            r_rotCnt <= 4'd0;
`endif
          end else begin
            r_imm12     <= 12'h000;
            r_encodable <= 1'b0;
`ifdef IMM_INV_EN
            r_inverted  <= 1'b0;
`endif
            r_outValid  <= 1'b1;
            r_state     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end

        default: begin
          r_outValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Handshake status decodes straight from state; results come from registers.
  assign bus.in_ready  = (r_state == IDLE);
  assign bus.busy      = (r_state == SEARCH);
  assign bus.out_valid = r_outValid;
  assign bus.imm12     = r_imm12;
  assign bus.encodable = r_encodable;
`ifdef IMM_INV_EN
  assign bus.inverted  = r_inverted;
`else
  assign bus.inverted  = 1'b0;
`endif

endmodule
